// File: rtl/piso_serializer_32.sv
// ---------------------------------------------------------------------------
// piso_serializer_32
//   Parallel-in / serial-out reader for a register word. One WIDTH-bit word is
//   accepted over an in_valid/in_ready handshake and replayed one bit per
//   accepted beat over an out_valid/out_ready handshake. out_last marks the
//   final beat of the word. Words never overlap: one idle cycle (in_ready=1)
//   separates consecutive words.
//
// Parameters
//   WIDTH      word width in bits (2..64)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Optional build macro
//   PISO_PARITY_EN  append one extra beat carrying the even parity (XOR) of
//                   the loaded word; out_last then marks the parity beat.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    parallel word to serialize
//   in_valid   in_data is valid
//   in_ready   serializer can accept a word
//   out_bit    current serial bit
//   out_valid  out_bit is valid
//   out_ready  sink accepts out_bit this cycle
//   out_last   current beat is the final beat of the word
//   busy       a word is in flight
// ---------------------------------------------------------------------------
module piso_serializer_32 #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
  // Counter value WIDTH..1 selects data beats, 0 selects the parity beat.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Low only between reset release and the first clock edge, so in_ready
  // stays low through reset and rises on the first cycle afterwards.
  logic               live_q;
  logic               load;
  logic               beat;
  logic               data_bit;

`ifdef PISO_PARITY_EN
  logic               par_q, par_d;
`endif

  // Move the word one position toward the output end, zero-filling behind.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  assign data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    beat      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
`ifdef PISO_PARITY_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        in_ready = live_q;
        load     = live_q & in_valid;
        if (load) begin
          shreg_d = in_data;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
`ifdef PISO_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (cnt_q == '0);
`ifdef PISO_PARITY_EN
        out_bit   = (cnt_q == '0) ? par_q : data_bit;
`else
        out_bit   = data_bit;
`endif
        beat = out_ready;
        if (beat) begin
          shreg_d = shift_one(shreg_q);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
